// File: rtl/alu_mdu_ctrl.sv
// ALU control decoder with an iterative RV M-extension multiply/divide engine.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module alu_mdu_ctrl #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            op5,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [1:0]      ALUOp,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic [3:0]      ALUControl,
  output logic            is_muldiv,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] mdu_result
);

  localparam int ITER = XLEN / UNROLL;
  localparam int CW   = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     mdu_result_q, mdu_result_d;

  logic                signed_a, signed_b, sign_a, sign_b, neg_new;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_zero, div_ovf, accept;
  logic [2*XLEN-1:0]   mul_next, div_next;

  // Shift-add step: acc = {partial_hi, multiplier_lo}, m is the multiplicand magnitude.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   m);
    logic [2*XLEN-1:0] r;
    logic [XLEN:0]     sum;
    r = acc;
    for (int i = 0; i < UNROLL; i++) begin
      sum = {1'b0, r[2*XLEN-1:XLEN]} + (r[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
      r   = {sum, r[XLEN-1:1]};
    end
    return r;
  endfunction

  // Restoring divide step: acc = {remainder, dividend/quotient}, d is the divisor magnitude.
  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   d);
    logic [2*XLEN-1:0] r;
    logic [XLEN:0]     sh, diff;
    r = acc;
    for (int i = 0; i < UNROLL; i++) begin
      sh   = {r[2*XLEN-1:XLEN], r[XLEN-1]};
      diff = sh - {1'b0, d};
      r    = diff[XLEN] ? {sh[XLEN-1:0], r[XLEN-2:0], 1'b0}
                        : {diff[XLEN-1:0], r[XLEN-2:0], 1'b1};
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] finalize(input logic [2:0]        op,
                                               input logic              neg,
                                               input logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   q, r, res;
    p = neg ? -acc : acc;
    q = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    r = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      3'b000:                 res = p[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res = p[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res = q;
      default:                res = r;
    endcase
    return res;
  endfunction

  // Base ALU control code and M-op detection.
  always_comb begin
    is_muldiv = (ALUOp == 2'b10) & op5 & (funct7 == 7'b0000001);
    case (ALUOp)
      2'b00:   ALUControl = 4'b0000;
      2'b01:   ALUControl = 4'b1000;
      2'b11:   ALUControl = 4'b1111;
      default: begin
        if (op5 || (funct3 == 3'b101)) begin
          ALUControl = {funct7[5], funct3};
        end else begin
          ALUControl = {1'b0, funct3};
        end
      end
    endcase
  end

  // Operand signedness, magnitudes and divide special cases for the incoming op.
  always_comb begin
    case (funct3)
      3'b001, 3'b100, 3'b110: begin signed_a = 1'b1; signed_b = 1'b1; end
      3'b010:                 begin signed_a = 1'b1; signed_b = 1'b0; end
      default:                begin signed_a = 1'b0; signed_b = 1'b0; end
    endcase
    sign_a = signed_a & src_a[XLEN-1];
    sign_b = signed_b & src_b[XLEN-1];
    mag_a  = sign_a ? -src_a : src_a;
    mag_b  = sign_b ? -src_b : src_b;
    case (funct3)
      3'b001, 3'b100: neg_new = sign_a ^ sign_b;
      3'b010, 3'b110: neg_new = sign_a;
      default:        neg_new = 1'b0;
    endcase
    div_zero = (src_b == {XLEN{1'b0}});
    div_ovf  = signed_b & funct3[2] & (src_a == {1'b1, {(XLEN-1){1'b0}}}) &
               (src_b == {XLEN{1'b1}});
    accept   = in_valid & is_muldiv & (state_q == S_IDLE) & ~flush;
  end

  assign busy       = (state_q != S_IDLE) | (in_valid & is_muldiv & (state_q == S_IDLE));
  assign out_valid  = out_valid_q;
  assign mdu_result = mdu_result_q;

  // Engine next-state: accept, iterate, finalize into the result register.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    neg_d        = neg_q;
    opnd_d       = opnd_q;
    acc_d        = acc_q;
    out_valid_d  = 1'b0;
    mdu_result_d = mdu_result_q;
    mul_next     = mul_step(acc_q, opnd_q);
    div_next     = div_step(acc_q, opnd_q);
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_d  = funct3;
            neg_d = neg_new;
            cnt_d = {CW{1'b0}};
            if (!funct3[2]) begin
`ifdef MDU_FAST_MUL_EN
              mdu_result_d = finalize(funct3, neg_new,
                                      {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b});
              out_valid_d  = 1'b1;
              state_d      = S_DONE;
`else
              acc_d   = {{XLEN{1'b0}}, mag_b};
              opnd_d  = mag_a;
              state_d = S_MUL;
`endif
            end else if (div_zero) begin
              mdu_result_d = funct3[1] ? src_a : {XLEN{1'b1}};
              out_valid_d  = 1'b1;
              state_d      = S_DONE;
            end else if (div_ovf) begin
              mdu_result_d = funct3[1] ? {XLEN{1'b0}} : src_a;
              out_valid_d  = 1'b1;
              state_d      = S_DONE;
            end else begin
              acc_d   = {{XLEN{1'b0}}, mag_a};
              opnd_d  = mag_b;
              state_d = S_DIV;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          acc_d = (state_q == S_MUL) ? mul_next : div_next;
          if (cnt_q == CNT_LAST) begin
            mdu_result_d = finalize(op_q, neg_q, acc_d);
            out_valid_d  = 1'b1;
            state_d      = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CW{1'b0}};
      op_q         <= 3'b000;
      neg_q        <= 1'b0;
      opnd_q       <= {XLEN{1'b0}};
      acc_q        <= {(2*XLEN){1'b0}};
      out_valid_q  <= 1'b0;
      mdu_result_q <= {XLEN{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      neg_q        <= neg_d;
      opnd_q       <= opnd_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      mdu_result_q <= mdu_result_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Scoreboard bench for alu_mdu_ctrl: UNROLL=1 and UNROLL=4 instances, directed vectors.
module tb_alu_mdu_ctrl;

`ifdef MDU_FAST_MUL_EN
  localparam int LM1 = 1;
  localparam int LM4 = 1;
`else
  localparam int LM1 = 33;
  localparam int LM4 = 9;
`endif
  localparam int LD1 = 33;
  localparam int LD4 = 9;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_valid4 = 1'b0;
  logic        op5 = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [6:0]  funct7 = 7'b0000000;
  logic [1:0]  ALUOp = 2'b00;
  logic [31:0] src_a = 32'h0, src_b = 32'h0;
  logic        flush = 1'b0;
  logic [3:0]  ALUControl, ALUControl4;
  logic        is_muldiv, is_muldiv4, busy, busy4, out_valid, out_valid4;
  logic [31:0] mdu_result, mdu_result4;

  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;

  alu_mdu_ctrl #(.XLEN(32), .UNROLL(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op5(op5), .funct3(funct3),
    .funct7(funct7), .ALUOp(ALUOp), .src_a(src_a), .src_b(src_b), .flush(flush),
    .ALUControl(ALUControl), .is_muldiv(is_muldiv), .busy(busy),
    .out_valid(out_valid), .mdu_result(mdu_result));

  alu_mdu_ctrl #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .op5(op5), .funct3(funct3),
    .funct7(funct7), .ALUOp(ALUOp), .src_a(src_a), .src_b(src_b), .flush(flush),
    .ALUControl(ALUControl4), .is_muldiv(is_muldiv4), .busy(busy4),
    .out_valid(out_valid4), .mdu_result(mdu_result4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: pop and compare whenever a DUT presents a result.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q1.size() == 0) begin
        chk("u1_spurious_valid", 64'd1, 64'd0);
      end else begin
        e1 = q1.pop_front();
        chk("u1_result", mdu_result, e1.val);
        chk("u1_latency", cyc, e1.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid4) begin
      if (q4.size() == 0) begin
        chk("u4_spurious_valid", 64'd1, 64'd0);
      end else begin
        e4 = q4.pop_front();
        chk("u4_result", mdu_result4, e4.val);
        chk("u4_latency", cyc, e4.cyc);
      end
    end
  end

  // Called at posedge+#1. Drives one M op for one cycle; optionally waits for completion.
  task automatic run_op(input int sel, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit push, input bit wait_done);
    exp_t e;
    bit   ok;
    int   i;
    ALUOp  = 2'b10;
    op5    = 1'b1;
    funct7 = 7'b0000001;
    funct3 = f3;
    src_a  = a;
    src_b  = b;
    e.val  = exp;
    e.cyc  = cyc + lat;
    if (sel == 4) begin
      in_valid4 = 1'b1;
      if (push) q4.push_back(e);
    end else begin
      in_valid = 1'b1;
      if (push) q1.push_back(e);
    end
    #1;
    chk("busy_accept", (sel == 4) ? busy4 : busy, 64'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
    if (wait_done) begin
      ok = 1'b1;
      for (i = 0; i < 100; i++) begin
        if (((sel == 4) ? q4.size() : q1.size()) == 0) break;
        if (((sel == 4) ? busy4 : busy) !== 1'b1) ok = 1'b0;
        @(posedge clk);
        #1;
      end
      chk("busy_hold", ok, 64'd1);
      chk("done_timeout", (sel == 4) ? q4.size() : q1.size(), 64'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 64'd0);
    chk("rst_busy", busy, 64'd0);
    chk("rst_result", mdu_result, 64'd0);

    // Base decode; in_valid high but non-M instructions must never stall.
    in_valid = 1'b1;
    ALUOp = 2'b10; op5 = 1'b0; funct3 = 3'b101; funct7 = 7'b0100000; #1;
    chk("dec_srai", ALUControl, 64'hD);
    chk("dec_busy0", busy, 64'd0);
    funct3 = 3'b000; #1;
    chk("dec_addi", ALUControl, 64'h0);
    op5 = 1'b1; #1;
    chk("dec_sub", ALUControl, 64'h8);
    chk("dec_sub_u4", ALUControl4, 64'h8);
    chk("dec_not_m", is_muldiv, 64'd0);
    ALUOp = 2'b01; #1;
    chk("dec_beq", ALUControl, 64'h8);
    ALUOp = 2'b11; #1;
    chk("dec_imm", ALUControl, 64'hF);
    ALUOp = 2'b00; #1;
    chk("dec_add", ALUControl, 64'h0);
    chk("dec_busy1", busy, 64'd0);
    in_valid = 1'b0;
    ALUOp = 2'b10; funct7 = 7'b0000001; #1;
    chk("dec_is_m", is_muldiv, 64'd1);
    chk("dec_is_m_u4", is_muldiv4, 64'd1);
    chk("dec_idle_busy", busy, 64'd0);
    @(posedge clk); #1;

    // Iterative multiply / divide, UNROLL=1.
    run_op(1, 3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, LM1, 1'b1, 1'b1);
    run_op(1, 3'b000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, LM1, 1'b1, 1'b1);
    run_op(1, 3'b010, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, LM1, 1'b1, 1'b1);
    run_op(1, 3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, LD1, 1'b1, 1'b1);
    run_op(1, 3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, LD1, 1'b1, 1'b1);
    run_op(1, 3'b101, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, LD1, 1'b1, 1'b1);
    run_op(1, 3'b111, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, LD1, 1'b1, 1'b1);
    run_op(1, 3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, LD1, 1'b1, 1'b1);
    run_op(1, 3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, LD1, 1'b1, 1'b1);

    // Special cases complete at cycle 1.
    run_op(1, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b1, 1'b1);
    run_op(1, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1'b1, 1'b1);
    run_op(1, 3'b100, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1, 1'b1, 1'b1);
    run_op(1, 3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1, 1'b1, 1'b1);
    run_op(1, 3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1, 1'b1, 1'b1);
    run_op(1, 3'b111, 32'h00000005, 32'h00000000, 32'h00000005, 1, 1'b1, 1'b1);

    // Flush at cycle 10 of a DIV, then MUL 6*7 accepted at cycle 12.
    run_op(1, 3'b100, 32'd100, 32'd7, 32'd0, LD1, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", busy, 64'd0);
    chk("flush_valid", out_valid, 64'd0);
    chk("flush_result", mdu_result, 64'd5);
    @(posedge clk); #1;
    run_op(1, 3'b000, 32'd6, 32'd7, 32'd42, LM1, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a MUL.
    run_op(1, 3'b000, 32'd9, 32'd9, 32'd0, LM1, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", out_valid, 64'd0);
    chk("arst_busy", busy, 64'd0);
    chk("arst_result", mdu_result, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("arst_idle", busy, 64'd0);

    // UNROLL=4 instance.
    run_op(4, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LM4, 1'b1, 1'b1);
    run_op(4, 3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, LD4, 1'b1, 1'b1);
    run_op(4, 3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, LD4, 1'b1, 1'b1);
    run_op(4, 3'b000, 32'd6, 32'd7, 32'd42, LM4, 1'b1, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    chk("drain", q1.size() + q4.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
